mig_seq_evaluator: RTL and testbench

Sequential majority-inverter-graph (MIG) evaluator. A single shared 3-input majority unit with per-operand inversion is time-multiplexed over a programmable node table, one node per cycle. The block sits beside the flattened combinational MIG netlists and executes any such netlist from a loaded table; the last node drives the primary output.

---
 rtl/mig_seq_evaluator_if.sv | 27 ++
 rtl/mig_seq_evaluator.sv | 145 ++++++++++++++
 tb/tb_mig_seq_evaluator.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mig_seq_evaluator_if.sv
// rtl/mig_seq_evaluator_if.sv - config, run-control and result signals of the MIG evaluator
interface mig_seq_evaluator_if #(
    parameter int NUM_PI  = 5,
    parameter int NODE_AW = 6,
    parameter int IDX_W   = 8
);
    logic                     cfg_we;
    logic [NODE_AW-1:0]       cfg_addr;
    logic [3*(IDX_W+1)-1:0]   cfg_data;
    logic [NODE_AW:0]         cfg_num_nodes;
    logic                     start;
    logic [NUM_PI-1:0]        pi;
    logic                     busy;
    logic                     done;
    logic                     po;
    logic                     err;

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_num_nodes, start, pi,
        input  busy, done, po, err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_num_nodes, start, pi,
        output busy, done, po, err
    );
endinterface

// File: rtl/mig_seq_evaluator.sv
// rtl/mig_seq_evaluator.sv - time-multiplexed majority-inverter-graph evaluator
// Optional MIG_STEP_EN: adds a step input that gates node advancement in EVAL.
module mig_seq_evaluator #(
    parameter int NUM_PI    = 5,
    parameter int MAX_NODES = 64,
    parameter int NODE_AW   = 6,
    parameter int IDX_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
`ifdef MIG_STEP_EN
    input  logic step,
`endif
    mig_seq_evaluator_if.slave bus
);
    localparam int OP_W  = IDX_W + 1;
    localparam int SIG_N = 1 << IDX_W;

    typedef enum logic {IDLE, EVAL} state_t;

    logic [3*OP_W-1:0]  node_tbl [MAX_NODES];

    state_t             state_q, state_d;
    logic [NODE_AW-1:0] ptr_q, ptr_d;
    logic [NODE_AW:0]   n_q, n_d;
    logic [NUM_PI-1:0]  pi_q, pi_d;
    logic [MAX_NODES-1:0] res_q, res_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               po_q, po_d;
    logic               err_q, err_d;

    logic [SIG_N-1:0]   sig_vec;
    logic [3*OP_W-1:0]  entry;
    logic [IDX_W:0]     idx_lim;
    logic [2:0]         op_val;
    logic               op_bad;
    logic               maj_r;
    logic               adv;

`ifdef MIG_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    // Signal space: bit 0 is constant 0, then latched PIs, then node results.
    assign sig_vec = SIG_N'({res_q, pi_q, 1'b0});
    assign entry   = node_tbl[ptr_q];
    assign idx_lim = (IDX_W+1)'(NUM_PI + 1) + (IDX_W+1)'(ptr_q);

    always_comb begin
        op_val = '0;
        op_bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if ({1'b0, entry[k*OP_W +: IDX_W]} >= idx_lim) op_bad = 1'b1;
            op_val[k] = sig_vec[entry[k*OP_W +: IDX_W]] ^ entry[k*OP_W + IDX_W];
        end
        maj_r = (op_val[0] & op_val[1]) | (op_val[0] & op_val[2]) | (op_val[1] & op_val[2]);
    end

    // The table is written only while idle, so a run always sees a stable program.
    always_ff @(posedge clk) begin
        if (bus.cfg_we && state_q == IDLE) node_tbl[bus.cfg_addr] <= bus.cfg_data;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        n_d     = n_q;
        pi_d    = pi_q;
        res_d   = res_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        po_d    = po_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.cfg_num_nodes == '0 ||
                        bus.cfg_num_nodes > (NODE_AW+1)'(MAX_NODES)) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        pi_d    = bus.pi;
                        n_d     = bus.cfg_num_nodes;
                        ptr_d   = '0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = EVAL;
                    end
                end
            end
            EVAL: begin
                if (adv) begin
                    if (op_bad) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        res_d[ptr_q] = maj_r;
                        if ({1'b0, ptr_q} == n_q - (NODE_AW+1)'(1)) begin
                            po_d    = maj_r;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            ptr_d = ptr_q + NODE_AW'(1);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            n_q     <= '0;
            pi_q    <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            po_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            n_q     <= n_d;
            pi_q    <= pi_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            po_q    <= po_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.po   = po_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_mig_seq_evaluator.sv
// tb/tb_mig_seq_evaluator.sv - directed self-checking bench for mig_seq_evaluator
module tb_mig_seq_evaluator;
    localparam int NUM_PI    = 5;
    localparam int MAX_NODES = 64;
    localparam int NODE_AW   = 6;
    localparam int IDX_W     = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
`ifdef MIG_STEP_EN
    logic step  = 1'b1;
`endif
    int total = 0;
    int bad   = 0;

    mig_seq_evaluator_if #(.NUM_PI(NUM_PI), .NODE_AW(NODE_AW), .IDX_W(IDX_W)) bus ();

    mig_seq_evaluator #(
        .NUM_PI(NUM_PI), .MAX_NODES(MAX_NODES), .NODE_AW(NODE_AW), .IDX_W(IDX_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
`ifdef MIG_STEP_EN
        .step (step),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] mk(input logic ci, input int c, input logic bi, input int b,
                                       input logic ai, input int a);
        return {ci, 8'(c), bi, 8'(b), ai, 8'(a)};
    endfunction

    task automatic write_node(input int addr, input logic [26:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 6'(addr);
        bus.cfg_data = d;
        @(posedge clk); #1;
        bus.cfg_we   = 1'b0;
    endtask

    task automatic run(input int n, input logic [4:0] p, output int cyc, output logic busy_seen);
        bus.start = 1'b1;
        bus.cfg_num_nodes = 7'(n);
        bus.pi = p;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        busy_seen = bus.busy;
        while (bus.done !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.busy === 1'b1) busy_seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.cfg_num_nodes = '0; bus.start = 1'b0; bus.pi = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.po   !== 1'b0) begin bad++; $display("FAIL reset_po got=%b want=0", bus.po); end
        total++; if (bus.err  !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int cyc; logic bs;
        write_node(0, mk(1, 0, 0, 2, 0, 1));
        write_node(1, mk(0, 0, 1, 5, 0, 6));
        run(2, 5'b00001, cyc, bs);
        total++; if (cyc !== 2)      begin bad++; $display("FAIL basic_latency got=%0d want=2", cyc); end
        total++; if (bs !== 1'b1)    begin bad++; $display("FAIL basic_busy_seen got=%b want=1", bs); end
        total++; if (bus.po !== 1'b1)  begin bad++; $display("FAIL basic_po1 got=%b want=1", bus.po); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", bus.err); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", bus.busy); end
        @(posedge clk); #1;
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b want=0", bus.done); end
        run(2, 5'b10001, cyc, bs);
        total++; if (bus.po !== 1'b0)  begin bad++; $display("FAIL basic_po2 got=%b want=0", bus.po); end
        total++; if (cyc !== 2)      begin bad++; $display("FAIL basic_latency2 got=%0d want=2", cyc); end
    endtask

    task automatic test_forward_ref;
        int cyc; logic bs;
        run(2, 5'b00001, cyc, bs);
        total++; if (bus.po !== 1'b1) begin bad++; $display("FAIL fwd_setup_po got=%b want=1", bus.po); end
        write_node(0, mk(0, 0, 0, 2, 0, 6));
        run(1, 5'b00000, cyc, bs);
        total++; if (cyc !== 1)        begin bad++; $display("FAIL fwd_latency got=%0d want=1", cyc); end
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL fwd_err got=%b want=1", bus.err); end
        total++; if (bus.po !== 1'b1)  begin bad++; $display("FAIL fwd_po_hold got=%b want=1", bus.po); end
        write_node(0, mk(0, 200, 0, 2, 0, 1));
        run(1, 5'b00000, cyc, bs);
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL range_err got=%b want=1", bus.err); end
        write_node(0, mk(1, 0, 0, 2, 0, 1));
        run(1, 5'b00000, cyc, bs);
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", bus.err); end
        total++; if (bus.po !== 1'b0)  begin bad++; $display("FAIL err_clear_po got=%b want=0", bus.po); end
    endtask

    task automatic test_busy_guard;
        int cyc; logic bs; logic stray;
        write_node(0, mk(1, 0, 0, 2, 0, 1));
        write_node(1, mk(0, 0, 1, 0, 0, 6));
        write_node(2, mk(0, 0, 1, 0, 0, 7));
        write_node(3, mk(0, 0, 1, 0, 0, 8));
        bus.start = 1'b1; bus.cfg_num_nodes = 7'd4; bus.pi = 5'b00001;
        @(posedge clk); #1;
        bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_data = mk(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cfg_we = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        total++; if (cyc !== 4)        begin bad++; $display("FAIL guard_latency got=%0d want=4", cyc); end
        total++; if (bus.po !== 1'b1)  begin bad++; $display("FAIL guard_po got=%b want=1", bus.po); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL guard_err got=%b want=0", bus.err); end
        stray = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (bus.busy !== 1'b0 || bus.done !== 1'b0) stray = 1'b1; end
        total++; if (stray !== 1'b0)   begin bad++; $display("FAIL guard_no_requeue got=%b want=0", stray); end
        run(4, 5'b00001, cyc, bs);
        total++; if (bus.po !== 1'b1)  begin bad++; $display("FAIL guard_table_kept got=%b want=1", bus.po); end
        write_node(0, mk(0, 0, 0, 0, 0, 0));
        run(4, 5'b00001, cyc, bs);
        total++; if (bus.po !== 1'b0)  begin bad++; $display("FAIL guard_new_data got=%b want=0", bus.po); end
        bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_data = mk(1, 0, 0, 2, 0, 1);
        run(4, 5'b00001, cyc, bs);
        bus.cfg_we = 1'b0;
        total++; if (bus.po !== 1'b1)  begin bad++; $display("FAIL write_first_po got=%b want=1", bus.po); end
        total++; if (cyc !== 4)        begin bad++; $display("FAIL write_first_latency got=%0d want=4", cyc); end
    endtask

    task automatic test_bad_count;
        int cyc; logic bs;
        run(0, 5'b00000, cyc, bs);
        total++; if (cyc !== 0)        begin bad++; $display("FAIL n0_latency got=%0d want=0", cyc); end
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL n0_err got=%b want=1", bus.err); end
        total++; if (bs !== 1'b0)      begin bad++; $display("FAIL n0_busy got=%b want=0", bs); end
        total++; if (bus.po !== 1'b1)  begin bad++; $display("FAIL n0_po_hold got=%b want=1", bus.po); end
        @(posedge clk); #1;
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL n0_done_width got=%b want=0", bus.done); end
        run(MAX_NODES + 1, 5'b00000, cyc, bs);
        total++; if (cyc !== 0)        begin bad++; $display("FAIL n65_latency got=%0d want=0", cyc); end
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL n65_err got=%b want=1", bus.err); end
        total++; if (bs !== 1'b0)      begin bad++; $display("FAIL n65_busy got=%b want=0", bs); end
        total++; if (bus.po !== 1'b1)  begin bad++; $display("FAIL n65_po_hold got=%b want=1", bus.po); end
    endtask

    task automatic test_full_table;
        int cyc; logic bs;
        write_node(0, mk(0, 0, 0, 3, 0, 3));
        for (int n = 1; n < MAX_NODES; n++) write_node(n, mk(0, 0, 0, 5 + n, 0, 5 + n));
        run(MAX_NODES, 5'b00100, cyc, bs);
        total++; if (cyc !== 64)       begin bad++; $display("FAIL full_latency got=%0d want=64", cyc); end
        total++; if (bus.po !== 1'b1)  begin bad++; $display("FAIL full_po1 got=%b want=1", bus.po); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL full_err got=%b want=0", bus.err); end
        run(MAX_NODES, 5'b11011, cyc, bs);
        total++; if (bus.po !== 1'b0)  begin bad++; $display("FAIL full_po0 got=%b want=0", bus.po); end
        total++; if (cyc !== 64)       begin bad++; $display("FAIL full_latency2 got=%0d want=64", cyc); end
    endtask

    task automatic test_reset_mid_run;
        int cyc; logic bs;
        run(8, 5'b00100, cyc, bs);
        total++; if (bus.po !== 1'b1)  begin bad++; $display("FAIL rst_setup_po got=%b want=1", bus.po); end
        bus.start = 1'b1; bus.cfg_num_nodes = 7'd8; bus.pi = 5'b00100;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b want=0", bus.done); end
        total++; if (bus.po   !== 1'b0) begin bad++; $display("FAIL rst_mid_po got=%b want=0", bus.po); end
        total++; if (bus.err  !== 1'b0) begin bad++; $display("FAIL rst_mid_err got=%b want=0", bus.err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(8, 5'b00100, cyc, bs);
        total++; if (cyc !== 8)        begin bad++; $display("FAIL rst_rerun_latency got=%0d want=8", cyc); end
        total++; if (bus.po !== 1'b1)  begin bad++; $display("FAIL rst_rerun_po got=%b want=1", bus.po); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_rerun_err got=%b want=0", bus.err); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_forward_ref;
        test_busy_guard;
        test_bad_count;
        test_full_table;
        test_reset_mid_run;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
